// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one memory port between two clients. A whole transaction is
// granted at a time: the request is accepted in IDLE, then the grant is
// held until every data beat of that burst has been moved.
//
// Ports:
//   clock, reset                  clock, asynchronous active-high reset
//   cN_req_* (N=0,1)              client request channel (valid/ready)
//   cN_wr_valid/bits              client write beats
//   cN_rd_valid/bits/ready        client read beats
//   mem_req_*                     request pulse to memory
//   mem_wr_valid/bits             write beats to memory (no back-pressure)
//   mem_rd_valid/bits/ready       read beats from memory
//
// Optional build macro: MEM_ARB_FIXED_PRIO_EN
//   defined   -> client 0 wins whenever both clients request
//   undefined -> round-robin between the two clients
module mem_arbiter #(
    parameter int MEM_LEN_BITS  = 8,
    parameter int MEM_ADDR_BITS = 64,
    parameter int MEM_DATA_BITS = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     c0_req_valid,
    input  logic                     c0_req_opcode,
    input  logic [MEM_LEN_BITS-1:0]  c0_req_len,
    input  logic [MEM_ADDR_BITS-1:0] c0_req_addr,
    output logic                     c0_req_ready,
    input  logic                     c0_wr_valid,
    input  logic [MEM_DATA_BITS-1:0] c0_wr_bits,
    output logic                     c0_rd_valid,
    output logic [MEM_DATA_BITS-1:0] c0_rd_bits,
    input  logic                     c0_rd_ready,
    input  logic                     c1_req_valid,
    input  logic                     c1_req_opcode,
    input  logic [MEM_LEN_BITS-1:0]  c1_req_len,
    input  logic [MEM_ADDR_BITS-1:0] c1_req_addr,
    output logic                     c1_req_ready,
    input  logic                     c1_wr_valid,
    input  logic [MEM_DATA_BITS-1:0] c1_wr_bits,
    output logic                     c1_rd_valid,
    output logic [MEM_DATA_BITS-1:0] c1_rd_bits,
    input  logic                     c1_rd_ready,
    output logic                     mem_req_valid,
    output logic                     mem_req_opcode,
    output logic [MEM_LEN_BITS-1:0]  mem_req_len,
    output logic [MEM_ADDR_BITS-1:0] mem_req_addr,
    output logic                     mem_wr_valid,
    output logic [MEM_DATA_BITS-1:0] mem_wr_bits,
    input  logic                     mem_rd_valid,
    input  logic [MEM_DATA_BITS-1:0] mem_rd_bits,
    output logic                     mem_rd_ready
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t                  r_state, w_state_next;
    logic                    r_owner, w_owner_next;
    logic                    r_last, w_last_next;
    logic [MEM_LEN_BITS-1:0] r_cnt, w_cnt_next;
    logic [MEM_LEN_BITS-1:0] r_len_q, w_len_q_next;

    logic w_any;
    logic w_sel;
    logic w_beat;
    logic w_rd_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;   // client 0 gets first priority after reset
            r_cnt   <= '0;
            r_len_q <= '0;
        end else begin
            r_state <= w_state_next;
            r_owner <= w_owner_next;
            r_last  <= w_last_next;
            r_cnt   <= w_cnt_next;
            r_len_q <= w_len_q_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_owner_next   = r_owner;
        w_last_next    = r_last;
        w_cnt_next     = r_cnt;
        w_len_q_next   = r_len_q;
        w_beat         = 1'b0;
        w_rd_ready     = 1'b0;

        c0_req_ready   = 1'b0;
        c1_req_ready   = 1'b0;
        c0_rd_valid    = 1'b0;
        c0_rd_bits     = '0;
        c1_rd_valid    = 1'b0;
        c1_rd_bits     = '0;
        mem_req_valid  = 1'b0;
        mem_req_opcode = 1'b0;
        mem_req_len    = '0;
        mem_req_addr   = '0;
        mem_wr_valid   = 1'b0;
        mem_wr_bits    = '0;
        mem_rd_ready   = 1'b0;

        w_any = c0_req_valid | c1_req_valid;
        // With a single requester, sel points at it (sel=1 iff client 0 idle).
`ifdef MEM_ARB_FIXED_PRIO_EN
        w_sel = ~c0_req_valid;
`else
        w_sel = (c0_req_valid && c1_req_valid) ? ~r_last : ~c0_req_valid;
`endif

        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    c0_req_ready   = ~w_sel;
                    c1_req_ready   = w_sel;
                    mem_req_valid  = 1'b1;
                    mem_req_opcode = w_sel ? c1_req_opcode : c0_req_opcode;
                    mem_req_len    = w_sel ? c1_req_len    : c0_req_len;
                    mem_req_addr   = w_sel ? c1_req_addr   : c0_req_addr;
                    w_owner_next   = w_sel;
                    w_last_next    = w_sel;
                    w_len_q_next   = mem_req_len;
                    w_cnt_next     = '0;
                    w_state_next   = mem_req_opcode ? S_WRITE : S_READ;
                end
            end
            S_READ: begin
                w_rd_ready   = r_owner ? c1_rd_ready : c0_rd_ready;
                mem_rd_ready = w_rd_ready;
                if (r_owner) begin
                    c1_rd_valid = mem_rd_valid;
                    c1_rd_bits  = mem_rd_bits;
                end else begin
                    c0_rd_valid = mem_rd_valid;
                    c0_rd_bits  = mem_rd_bits;
                end
                w_beat = mem_rd_valid & w_rd_ready;
            end
            S_WRITE: begin
                mem_wr_valid = r_owner ? c1_wr_valid : c0_wr_valid;
                mem_wr_bits  = r_owner ? c1_wr_bits  : c0_wr_bits;
                w_beat       = r_owner ? c1_wr_valid : c0_wr_valid;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // The equality test against len_q ends the burst before cnt could
        // ever wrap, so len = all-ones still yields 2^MEM_LEN_BITS beats.
        if (w_beat) begin
            if (r_cnt == r_len_q) begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end else begin
                w_cnt_next = r_cnt + MEM_LEN_BITS'(1);
            end
        end

        // Every output is forced low while reset is held.
        if (reset) begin
            c0_req_ready   = 1'b0;
            c1_req_ready   = 1'b0;
            c0_rd_valid    = 1'b0;
            c0_rd_bits     = '0;
            c1_rd_valid    = 1'b0;
            c1_rd_bits     = '0;
            mem_req_valid  = 1'b0;
            mem_req_opcode = 1'b0;
            mem_req_len    = '0;
            mem_req_addr   = '0;
            mem_wr_valid   = 1'b0;
            mem_wr_bits    = '0;
            mem_rd_ready   = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter: reset, single read, contention, write
// while busy, read back-pressure, maximum burst length, reset mid-burst.
module tb_mem_arbiter;

`ifdef MEM_ARB_FIXED_PRIO_EN
    localparam logic FIXED = 1'b1;
`else
    localparam logic FIXED = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        c0_req_valid, c0_req_opcode, c0_req_ready;
    logic [7:0]  c0_req_len;
    logic [63:0] c0_req_addr;
    logic        c0_wr_valid;
    logic [63:0] c0_wr_bits;
    logic        c0_rd_valid, c0_rd_ready;
    logic [63:0] c0_rd_bits;
    logic        c1_req_valid, c1_req_opcode, c1_req_ready;
    logic [7:0]  c1_req_len;
    logic [63:0] c1_req_addr;
    logic        c1_wr_valid;
    logic [63:0] c1_wr_bits;
    logic        c1_rd_valid, c1_rd_ready;
    logic [63:0] c1_rd_bits;
    logic        mem_req_valid, mem_req_opcode;
    logic [7:0]  mem_req_len;
    logic [63:0] mem_req_addr;
    logic        mem_wr_valid;
    logic [63:0] mem_wr_bits;
    logic        mem_rd_valid, mem_rd_ready;
    logic [63:0] mem_rd_bits;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    mem_arbiter dut (
        .clock(clock), .reset(reset),
        .c0_req_valid(c0_req_valid), .c0_req_opcode(c0_req_opcode),
        .c0_req_len(c0_req_len), .c0_req_addr(c0_req_addr),
        .c0_req_ready(c0_req_ready), .c0_wr_valid(c0_wr_valid),
        .c0_wr_bits(c0_wr_bits), .c0_rd_valid(c0_rd_valid),
        .c0_rd_bits(c0_rd_bits), .c0_rd_ready(c0_rd_ready),
        .c1_req_valid(c1_req_valid), .c1_req_opcode(c1_req_opcode),
        .c1_req_len(c1_req_len), .c1_req_addr(c1_req_addr),
        .c1_req_ready(c1_req_ready), .c1_wr_valid(c1_wr_valid),
        .c1_wr_bits(c1_wr_bits), .c1_rd_valid(c1_rd_valid),
        .c1_rd_bits(c1_rd_bits), .c1_rd_ready(c1_rd_ready),
        .mem_req_valid(mem_req_valid), .mem_req_opcode(mem_req_opcode),
        .mem_req_len(mem_req_len), .mem_req_addr(mem_req_addr),
        .mem_wr_valid(mem_wr_valid), .mem_wr_bits(mem_wr_bits),
        .mem_rd_valid(mem_rd_valid), .mem_rd_bits(mem_rd_bits),
        .mem_rd_ready(mem_rd_ready)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        c0_req_valid = 0; c0_req_opcode = 0; c0_req_len = 0; c0_req_addr = 0;
        c1_req_valid = 0; c1_req_opcode = 0; c1_req_len = 0; c1_req_addr = 0;
        c0_wr_valid = 0; c0_wr_bits = 0; c1_wr_valid = 0; c1_wr_bits = 0;
        c0_rd_ready = 0; c1_rd_ready = 0;
        mem_rd_valid = 0; mem_rd_bits = 0;
    endtask

    // One completed read beat to the owning client, then advance a cycle.
    task automatic rd_beat(input string tag, input logic own, input logic [63:0] d);
        mem_rd_valid = 1; mem_rd_bits = d; c0_rd_ready = 1; c1_rd_ready = 1;
        #2;
        chk1({tag, "_mem_rd_ready"}, mem_rd_ready, 1'b1);
        if (own) begin
            chk1({tag, "_c1_rd_valid"}, c1_rd_valid, 1'b1);
            chk64({tag, "_c1_rd_bits"}, c1_rd_bits, d);
            chk1({tag, "_c0_rd_valid"}, c0_rd_valid, 1'b0);
            chk64({tag, "_c0_rd_bits"}, c0_rd_bits, 64'h0);
        end else begin
            chk1({tag, "_c0_rd_valid"}, c0_rd_valid, 1'b1);
            chk64({tag, "_c0_rd_bits"}, c0_rd_bits, d);
            chk1({tag, "_c1_rd_valid"}, c1_rd_valid, 1'b0);
            chk64({tag, "_c1_rd_bits"}, c1_rd_bits, 64'h0);
        end
        $display("beat %s owner=%0d data=%0h", tag, own, d);
        cyc();
        mem_rd_valid = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        #2;
        chk1("rst_c0_req_ready", c0_req_ready, 1'b0);
        chk1("rst_c1_req_ready", c1_req_ready, 1'b0);
        chk1("rst_mem_req_valid", mem_req_valid, 1'b0);
        chk1("rst_mem_rd_ready", mem_rd_ready, 1'b0);
        chk1("rst_c0_rd_valid", c0_rd_valid, 1'b0);
        cyc();
        reset = 0;
        $display("reset applied");
    endtask

    initial begin
        clear_inputs();
        reset = 1;
        cyc();
        // Request held during reset must not leak out.
        c0_req_valid = 1; c1_req_valid = 1; mem_rd_valid = 1;
        do_reset();
        clear_inputs();
        #1;

        // ---------------- single read ----------------
        c0_req_valid = 1; c0_req_opcode = 0; c0_req_len = 8'd3; c0_req_addr = 64'h100;
        #2;
        chk1("rd1_c0_req_ready", c0_req_ready, 1'b1);
        chk1("rd1_c1_req_ready", c1_req_ready, 1'b0);
        chk1("rd1_mem_req_valid", mem_req_valid, 1'b1);
        chk1("rd1_mem_req_opcode", mem_req_opcode, 1'b0);
        chk8("rd1_mem_req_len", mem_req_len, 8'd3);
        chk64("rd1_mem_req_addr", mem_req_addr, 64'h100);
        $display("req c0 read len=3 addr=100");
        cyc();
        c0_req_valid = 0;
        #2;
        chk1("rd1_pulse_end", mem_req_valid, 1'b0);
        for (int i = 0; i < 4; i++) rd_beat("rd1", 1'b0, 64'hA + 64'(i));
        mem_rd_valid = 1; c0_rd_ready = 1;
        #2;
        chk1("rd1_idle_c0_rd_valid", c0_rd_valid, 1'b0);
        chk1("rd1_idle_mem_rd_ready", mem_rd_ready, 1'b0);
        clear_inputs();
        cyc();

        // ---------------- contention ----------------
        do_reset();
        c0_req_valid = 1; c0_req_addr = 64'h10;
        c1_req_valid = 1; c1_req_addr = 64'h20;
        #2;
        chk1("arb1_c0_ready", c0_req_ready, 1'b1);
        chk1("arb1_c1_ready", c1_req_ready, 1'b0);
        $display("contention grant 1");
        cyc();
        #1;
        chk1("arb1_busy_c0_ready", c0_req_ready, 1'b0);
        chk1("arb1_busy_c1_ready", c1_req_ready, 1'b0);
        rd_beat("arb1", 1'b0, 64'h51);
        #2;
        chk1("arb2_c0_ready", c0_req_ready, FIXED);
        chk1("arb2_c1_ready", c1_req_ready, ~FIXED);
        chk64("arb2_mem_req_addr", mem_req_addr, FIXED ? 64'h10 : 64'h20);
        $display("contention grant 2");
        cyc();
        rd_beat("arb2", ~FIXED, 64'h52);
        #2;
        chk1("arb3_c0_ready", c0_req_ready, 1'b1);
        chk1("arb3_c1_ready", c1_req_ready, 1'b0);
        $display("contention grant 3");
        cyc();
        c0_req_valid = 0; c1_req_valid = 0;
        rd_beat("arb3", 1'b0, 64'h53);
        clear_inputs();
        cyc();

        // ---------------- write while busy ----------------
        c1_req_valid = 1; c1_req_opcode = 1; c1_req_len = 8'd1; c1_req_addr = 64'h200;
        #2;
        chk1("wr_c1_ready", c1_req_ready, 1'b1);
        chk1("wr_mem_req_opcode", mem_req_opcode, 1'b1);
        $display("req c1 write len=1 addr=200");
        cyc();
        c1_req_valid = 0;
        c0_req_valid = 1; c0_req_opcode = 0; c0_req_len = 8'd0; c0_req_addr = 64'h300;
        c1_wr_valid = 1; c1_wr_bits = 64'h11;
        c0_wr_valid = 1; c0_wr_bits = 64'h99;
        #2;
        chk1("wr_b0_valid", mem_wr_valid, 1'b1);
        chk64("wr_b0_bits", mem_wr_bits, 64'h11);
        chk1("wr_b0_c0_ready", c0_req_ready, 1'b0);
        chk1("wr_b0_mem_req_valid", mem_req_valid, 1'b0);
        cyc();
        c1_wr_valid = 0;
        #2;
        chk1("wr_gap_valid", mem_wr_valid, 1'b0);
        chk1("wr_gap_c0_ready", c0_req_ready, 1'b0);
        cyc();
        c1_wr_valid = 1; c1_wr_bits = 64'h22;
        #2;
        chk1("wr_b1_valid", mem_wr_valid, 1'b1);
        chk64("wr_b1_bits", mem_wr_bits, 64'h22);
        chk1("wr_b1_c0_ready", c0_req_ready, 1'b0);
        cyc();
        c1_wr_valid = 0; c0_wr_valid = 0;
        #2;
        chk1("wr_done_c0_ready", c0_req_ready, 1'b1);
        chk1("wr_done_mem_wr_valid", mem_wr_valid, 1'b0);
        chk64("wr_done_addr", mem_req_addr, 64'h300);
        $display("write done, c0 granted");
        cyc();
        c0_req_valid = 0;
        rd_beat("wr_rd", 1'b0, 64'h33);
        clear_inputs();
        cyc();

        // ---------------- read back-pressure ----------------
        c0_req_valid = 1; c0_req_len = 8'd2; c0_req_addr = 64'h400;
        #2;
        chk1("bp_c0_ready", c0_req_ready, 1'b1);
        cyc();
        c0_req_valid = 0;
        rd_beat("bp0", 1'b0, 64'hB0);
        for (int i = 0; i < 3; i++) begin
            mem_rd_valid = 1; mem_rd_bits = 64'hB1; c0_rd_ready = 0;
            #2;
            chk1("bp_stall_mem_rd_ready", mem_rd_ready, 1'b0);
            chk1("bp_stall_c0_rd_valid", c0_rd_valid, 1'b1);
            $display("stall %0d", i);
            cyc();
        end
        rd_beat("bp1", 1'b0, 64'hB1);
        rd_beat("bp2", 1'b0, 64'hB2);
        mem_rd_valid = 1; c0_rd_ready = 1;
        #2;
        chk1("bp_idle_c0_rd_valid", c0_rd_valid, 1'b0);
        clear_inputs();
        cyc();

        // ---------------- max length ----------------
        c1_req_valid = 1; c1_req_len = 8'hFF; c1_req_addr = 64'h800;
        #2;
        chk1("max_c1_ready", c1_req_ready, 1'b1);
        chk8("max_len", mem_req_len, 8'hFF);
        cyc();
        c1_req_valid = 0;
        for (int i = 0; i < 256; i++) rd_beat("max", 1'b1, 64'h1000 + 64'(i));
        mem_rd_valid = 1; c1_rd_ready = 1;
        #2;
        chk1("max_idle_c1_rd_valid", c1_rd_valid, 1'b0);
        chk1("max_idle_mem_rd_ready", mem_rd_ready, 1'b0);
        clear_inputs();
        cyc();

        // ---------------- reset mid-burst ----------------
        // Leave last pointing at client 0 so priority after reset is visible.
        c0_req_valid = 1; c0_req_len = 8'd7; c0_req_addr = 64'h900;
        #2;
        chk1("rm_c0_ready", c0_req_ready, 1'b1);
        cyc();
        c0_req_valid = 0;
        rd_beat("rm0", 1'b0, 64'hC0);
        rd_beat("rm1", 1'b0, 64'hC1);
        mem_rd_valid = 1; mem_rd_bits = 64'hC2; c0_rd_ready = 1;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            mem_rd_valid = 1; mem_rd_bits = 64'hC2 + 64'(i); c0_rd_ready = 1; c1_rd_ready = 1;
            #2;
            chk1("rm_stray_c0_rd_valid", c0_rd_valid, 1'b0);
            chk1("rm_stray_c1_rd_valid", c1_rd_valid, 1'b0);
            chk1("rm_stray_mem_rd_ready", mem_rd_ready, 1'b0);
            $display("stray beat %0d dropped", i);
            cyc();
        end
        clear_inputs();
        c0_req_valid = 1; c0_req_addr = 64'hA0;
        c1_req_valid = 1; c1_req_addr = 64'hB0;
        #2;
        chk1("rm_after_c0_ready", c0_req_ready, 1'b1);
        chk1("rm_after_c1_ready", c1_req_ready, 1'b0);
        chk64("rm_after_addr", mem_req_addr, 64'hA0);
        $display("post-reset grant to c0");
        cyc();
        clear_inputs();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
